sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single 8-bit SDRAM controller port between two requesters:
  - the ROM/VHD download stream from data_io (ioctl);
  - the CPU-side SRAM-style bus from rememotech.
- Replaces the combinational ioctl_download mux.
- Download writes are buffered in a small FIFO so ioctl_wr strobes are never lost while the SDRAM is busy.
- CPU accesses are sequenced with an SRAM_RDY-style handshake.

Parameters:
AW, 23, byte address width
FIFO_DEPTH, 4, download write buffer entries (power of 2, >=2)

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
dl_active  in  1  ioctl_download level
dl_wr  in  1  ioctl_wr one-cycle strobe
dl_addr  in  AW  ioctl_addr
dl_data  in  8  ioctl_data
dl_overflow  out  1  sticky: strobe arrived with FIFO full
cpu_cs_n  in  1  SRAM chip select
cpu_oe_n  in  1  SRAM output enable (read)
cpu_we_n  in  1  SRAM write enable
cpu_addr  in  AW  CPU address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, registered
cpu_rdy  out  1  access complete
mem_addr  out  AW  to sdram addr
mem_din  out  8  to sdram din
mem_we  out  1  one-cycle write command
mem_rd  out  1  one-cycle read command
mem_dout  in  8  from sdram dout
mem_ready  in  1  sdram idle/complete

Behaviour:
- Reset (reset_n low, async):
  - state IDLE, FIFO empty;
  - mem_we=0, mem_rd=0, mem_addr=0, mem_din=0;
  - cpu_dout=0, cpu_rdy=0, dl_overflow=0.
- SDRAM contract:
  - command accepted only when mem_ready=1 in the cycle mem_we/mem_rd is high;
  - mem_ready falls the next cycle;
  - completion is mem_ready rising; read data is valid on mem_dout in that cycle.
- FIFO:
  - {dl_addr, dl_data} pushed on dl_wr while not full.
  - dl_wr while full: entry dropped, dl_overflow set.
  - dl_overflow clears only on reset or on a dl_active rising edge.
  - Simultaneous push and pop on a full FIFO is allowed; count is unchanged and nothing is dropped.
- CPU request: cpu_req = !cpu_cs_n && (!cpu_oe_n || !cpu_we_n). Write has precedence if both enables are low.
- FSM states:
  - IDLE:
    - FIFO non-empty and mem_ready -> ISSUE_DL.
    - Otherwise cpu_req && !dl_active && !cpu_done && mem_ready -> ISSUE_CPU.
  - ISSUE_DL: one-cycle mem_we with FIFO head; pop; -> WAIT_DL.
  - WAIT_DL: wait for mem_ready=1 (not earlier than the cycle after issue); -> IDLE.
  - ISSUE_CPU:
    - latch cpu_addr and op;
    - one-cycle mem_we (data cpu_din) or mem_rd;
    - -> WAIT_CPU.
  - WAIT_CPU: on mem_ready, capture mem_dout into cpu_dout if read; set cpu_done; -> IDLE.
- cpu_done / cpu_rdy:
  - cpu_rdy = cpu_done registered.
  - cpu_done clears when cpu_req falls or cpu_addr differs from the latched address. cpu_rdy drops the cycle after that.
  - A held request is never re-issued.
- Priority:
  - download FIFO always wins;
  - CPU is starved while dl_active=1 (the CPU is held in reset then);
  - a CPU access already in WAIT_CPU completes before a download is served.
- Latency with mem_ready continuously high except during access: CPU request to cpu_rdy = 3 cycles + SDRAM busy time.
- dl_active falling with FIFO non-empty: FIFO drains before any CPU access.
- Mid-operation reset: everything is abandoned immediately. A command in flight at the SDRAM is not tracked; the FSM restarts in IDLE and waits for mem_ready.

Decomposition:
- Package sdram_arb_pkg:
  - state enum (IDLE, ISSUE_DL, WAIT_DL, ISSUE_CPU, WAIT_CPU);
  - localparam DL_ENTRY_W = AW+8.
- Sub-module dl_wr_fifo: synchronous FIFO (clk_sys, reset_n, push, pop, wdata, rdata, full, empty), parameterised by width and depth; head available combinationally.

Test Plan:
- CPU read: mem model returns 8'hA5 after 5 cycles busy; cpu_cs_n=0, cpu_oe_n=0, addr 23'h001234 -> one mem_rd with addr 23'h001234, cpu_dout=8'hA5, cpu_rdy=1 until cs_n=1; no second mem_rd.
- Download burst: dl_active=1, 4 dl_wr strobes back-to-back (addr 0..3, data 10..13), mem busy 6 cycles each -> 4 mem_we in order with correct addr/data, dl_overflow=0.
- Overflow: FIFO_DEPTH=4, mem_ready held low, 5 strobes -> dl_overflow=1, first 4 entries written once mem_ready=1, fifth absent; next dl_active rise clears flag.
- Contention: CPU write pending while dl_active falls with 2 FIFO entries -> both download writes issue before the CPU mem_we; cpu_rdy rises only after the CPU write completes.
- CPU address change with cs_n held low: read 23'h10 completes, address changes to 23'h11 -> cpu_rdy drops, a new mem_rd is issued for 23'h11.
- Reset mid-access: assert reset_n=0 during WAIT_CPU -> all outputs 0 asynchronously; after release, no spurious mem_we/mem_rd until a new request.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and the
// download FIFO entry width ({addr, data}).
package sdram_arb_pkg;

   localparam int ARB_AW     = 23;
   localparam int DL_ENTRY_W = ARB_AW + 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_DL,
      WAIT_DL,
      ISSUE_CPU,
      WAIT_CPU
   } arb_state_t;

endpackage

// File: rtl/dl_wr_fifo.sv
// Small synchronous FIFO buffering ioctl download writes; the head entry is
// visible combinationally on rdata. A push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module dl_wr_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single 8-bit SDRAM controller port between the buffered ioctl
// download stream (always preferred) and the CPU SRAM-style bus.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW         = ARB_AW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_overflow,
   input  logic          cpu_cs_n,
   input  logic          cpu_oe_n,
   input  logic          cpu_we_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_rdy,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ready
);

   localparam int ENTRY_W = AW + (DL_ENTRY_W - ARB_AW);

   arb_state_t          state_q, state_d;
   logic [AW-1:0]       mem_addr_q, mem_addr_d;
   logic [7:0]          mem_din_q, mem_din_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_rd_q, mem_rd_d;
   logic [7:0]          cpu_dout_q, cpu_dout_d;
   logic                cpu_done_q, cpu_done_d;
   logic                cpu_rdy_q, cpu_rdy_d;
   logic [AW-1:0]       cpu_lat_addr_q, cpu_lat_addr_d;
   logic                cpu_op_wr_q, cpu_op_wr_d;
   logic                dl_overflow_q, dl_overflow_d;
   logic                dl_active_q, dl_active_d;

   logic                fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
   logic                cpu_req, cpu_wr, cpu_complete;

   assign cpu_req    = !cpu_cs_n && (!cpu_oe_n || !cpu_we_n);
   assign cpu_wr     = !cpu_we_n;
   assign fifo_wdata = {dl_addr, dl_data};
   assign fifo_pop   = (state_q == ISSUE_DL);

   dl_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .push    (dl_wr),
      .pop     (fifo_pop),
      .wdata   (fifo_wdata),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Command outputs are registered: they are loaded on entry to ISSUE_*,
   // so the strobe is high exactly during the ISSUE_* cycle.
   always_comb begin
      state_d        = state_q;
      mem_addr_d     = mem_addr_q;
      mem_din_d      = mem_din_q;
      mem_we_d       = 1'b0;
      mem_rd_d       = 1'b0;
      cpu_dout_d     = cpu_dout_q;
      cpu_lat_addr_d = cpu_lat_addr_q;
      cpu_op_wr_d    = cpu_op_wr_q;
      cpu_complete   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && mem_ready) begin
               state_d    = ISSUE_DL;
               mem_we_d   = 1'b1;
               mem_addr_d = fifo_rdata[ENTRY_W-1:8];
               mem_din_d  = fifo_rdata[7:0];
            end else if (cpu_req && !dl_active && !cpu_done_q && mem_ready) begin
               state_d        = ISSUE_CPU;
               cpu_lat_addr_d = cpu_addr;
               cpu_op_wr_d    = cpu_wr;
               mem_addr_d     = cpu_addr;
               mem_din_d      = cpu_din;
               mem_we_d       = cpu_wr;
               mem_rd_d       = !cpu_wr;
            end
         end
         ISSUE_DL:  state_d = WAIT_DL;
         WAIT_DL: begin
            if (mem_ready) state_d = IDLE;
         end
         ISSUE_CPU: state_d = WAIT_CPU;
         WAIT_CPU: begin
            if (mem_ready) begin
               state_d      = IDLE;
               cpu_complete = 1'b1;
               if (!cpu_op_wr_q) cpu_dout_d = mem_dout;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_done_d = cpu_done_q;
      if (cpu_complete) begin
         cpu_done_d = 1'b1;
      end else if (!cpu_req || (cpu_addr != cpu_lat_addr_q)) begin
         cpu_done_d = 1'b0;
      end
      cpu_rdy_d   = cpu_done_q;
      dl_active_d = dl_active;
      // A strobe rejected while full raises the flag even on an active rise.
      dl_overflow_d = dl_overflow_q;
      if (dl_active && !dl_active_q) dl_overflow_d = 1'b0;
      if (dl_wr && fifo_full && !fifo_pop) dl_overflow_d = 1'b1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         mem_we_q       <= 1'b0;
         mem_rd_q       <= 1'b0;
         cpu_dout_q     <= '0;
         cpu_done_q     <= 1'b0;
         cpu_rdy_q      <= 1'b0;
         cpu_lat_addr_q <= '0;
         cpu_op_wr_q    <= 1'b0;
         dl_overflow_q  <= 1'b0;
         dl_active_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_addr_q     <= mem_addr_d;
         mem_din_q      <= mem_din_d;
         mem_we_q       <= mem_we_d;
         mem_rd_q       <= mem_rd_d;
         cpu_dout_q     <= cpu_dout_d;
         cpu_done_q     <= cpu_done_d;
         cpu_rdy_q      <= cpu_rdy_d;
         cpu_lat_addr_q <= cpu_lat_addr_d;
         cpu_op_wr_q    <= cpu_op_wr_d;
         dl_overflow_q  <= dl_overflow_d;
         dl_active_q    <= dl_active_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign mem_we      = mem_we_q;
   assign mem_rd      = mem_rd_q;
   assign cpu_dout    = cpu_dout_q;
   assign cpu_rdy     = cpu_rdy_q;
   assign dl_overflow = dl_overflow_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural SDRAM that logs
// every accepted command and holds mem_ready low for a programmable time.
module tb_sdram_port_arbiter;

   typedef struct {
      logic        we;
      logic [22:0] addr;
      logic [7:0]  data;
   } cmd_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        dl_active, dl_wr;
   logic [22:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_overflow;
   logic        cpu_cs_n, cpu_oe_n, cpu_we_n;
   logic [22:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_rdy;
   logic [22:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we, mem_rd;
   logic [7:0]  mem_dout  = 8'h00;
   logic        mem_ready = 1'b1;

   cmd_t        log_q[$];
   int          busy_cycles = 5;
   int          busy_cnt    = 0;
   logic        hold_low    = 1'b0;
   logic [7:0]  rd_val      = 8'h00;
   int          bad_cmd     = 0;
   int          n_assert    = 0;
   int          n_fail      = 0;
   int          base;
   bit          seen;

   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter #(.AW(23), .FIFO_DEPTH(4)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .dl_overflow (dl_overflow),
      .cpu_cs_n    (cpu_cs_n),
      .cpu_oe_n    (cpu_oe_n),
      .cpu_we_n    (cpu_we_n),
      .cpu_addr    (cpu_addr),
      .cpu_din     (cpu_din),
      .cpu_dout    (cpu_dout),
      .cpu_rdy     (cpu_rdy),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_dout    (mem_dout),
      .mem_ready   (mem_ready)
   );

   // SDRAM model: the arbiter's reset does not reach it.
   always @(posedge clk_sys) begin
      if (mem_ready) begin
         if (mem_we || mem_rd) begin
            log_q.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_din : 8'h00)});
            mem_ready <= 1'b0;
            busy_cnt  <= busy_cycles;
         end else if (hold_low) begin
            mem_ready <= 1'b0;
         end
      end else begin
         if (mem_we || mem_rd) bad_cmd <= bad_cmd + 1;
         if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
         end else if (!hold_low) begin
            mem_ready <= 1'b1;
            mem_dout  <= rd_val;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic wait_log(input string tag, input int n, input int bound);
      int k = 0;
      while (log_q.size() < n && k < bound) begin
         @(negedge clk_sys);
         k++;
      end
      check(tag, 32'(log_q.size() >= n), 32'd1);
   endtask

   task automatic wait_rdy(input string tag, input int bound);
      int k = 0;
      while (cpu_rdy !== 1'b1 && k < bound) begin
         @(negedge clk_sys);
         k++;
      end
      check(tag, 32'(cpu_rdy), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      cpu_cs_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1; cpu_addr = '0; cpu_din = '0;
      step(3);
      check("rst_mem_we",   32'(mem_we), 32'd0);
      check("rst_mem_rd",   32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din",  32'(mem_din), 32'd0);
      check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
      check("rst_cpu_rdy",  32'(cpu_rdy), 32'd0);
      check("rst_dl_ovf",   32'(dl_overflow), 32'd0);
      reset_n = 1'b1;
      step(3);
      check("idle_no_cmd", 32'(log_q.size()), 32'd0);

      // CPU read of 0x001234, 5 busy cycles, data A5
      rd_val = 8'hA5; busy_cycles = 5;
      cpu_addr = 23'h001234; cpu_cs_n = 1'b0; cpu_oe_n = 1'b0;
      wait_rdy("rd_rdy", 40);
      check("rd_cmd_cnt",  32'(log_q.size()), 32'd1);
      check("rd_cmd_op",   32'(log_q[0].we), 32'd0);
      check("rd_cmd_addr", 32'(log_q[0].addr), 32'h1234);
      check("rd_dout",     32'(cpu_dout), 32'hA5);
      step(10);
      check("rd_held_rdy",  32'(cpu_rdy), 32'd1);
      check("rd_no_reissue", 32'(log_q.size()), 32'd1);
      cpu_cs_n = 1'b1; cpu_oe_n = 1'b1;
      step(1);
      check("rd_rdy_lag", 32'(cpu_rdy), 32'd1);
      step(1);
      check("rd_rdy_drop", 32'(cpu_rdy), 32'd0);
      step(10);

      // Download burst, 4 back-to-back strobes, 6 busy cycles each
      log_q.delete();
      busy_cycles = 6;
      dl_active = 1'b1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         dl_addr = 23'(i); dl_data = 8'(8'h10 + i); dl_wr = 1'b1;
         step(1);
      end
      dl_wr = 1'b0;
      wait_log("dl_wait", 4, 100);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("dl_we_%0d", i),   32'(log_q[i].we), 32'd1);
         check($sformatf("dl_addr_%0d", i), 32'(log_q[i].addr), 32'(i));
         check($sformatf("dl_data_%0d", i), 32'(log_q[i].data), 32'(8'h10 + i));
      end
      check("dl_no_ovf", 32'(dl_overflow), 32'd0);
      step(12);
      check("dl_cnt_final", 32'(log_q.size()), 32'd4);
      dl_active = 1'b0;
      step(2);

      // Overflow: SDRAM held busy, 5 strobes into a 4-entry FIFO
      log_q.delete();
      busy_cycles = 3;
      hold_low = 1'b1;
      step(2);
      dl_active = 1'b1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         dl_addr = 23'(8'h20 + i); dl_data = 8'(8'h20 + i); dl_wr = 1'b1;
         step(1);
      end
      dl_wr = 1'b0;
      step(1);
      check("ovf_set",      32'(dl_overflow), 32'd1);
      check("ovf_held_cnt", 32'(log_q.size()), 32'd0);
      hold_low = 1'b0;
      wait_log("ovf_drain", 4, 100);
      step(40);
      check("ovf_fifth_absent", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_addr_%0d", i), 32'(log_q[i].addr), 32'(8'h20 + i));
         check($sformatf("ovf_data_%0d", i), 32'(log_q[i].data), 32'(8'h20 + i));
      end
      check("ovf_sticky", 32'(dl_overflow), 32'd1);
      dl_active = 1'b0;
      step(1);
      check("ovf_fall_keeps", 32'(dl_overflow), 32'd1);
      dl_active = 1'b1;
      step(2);
      check("ovf_clear_on_rise", 32'(dl_overflow), 32'd0);
      dl_active = 1'b0;
      step(2);

      // Contention: CPU write pending while dl_active falls with 2 entries queued
      log_q.delete();
      busy_cycles = 4;
      hold_low = 1'b1;
      step(2);
      dl_active = 1'b1;
      step(1);
      for (int i = 0; i < 2; i++) begin
         dl_addr = 23'(8'h30 + i); dl_data = 8'(8'h30 + i); dl_wr = 1'b1;
         step(1);
      end
      dl_wr = 1'b0;
      cpu_addr = 23'h000040; cpu_din = 8'h77; cpu_cs_n = 1'b0; cpu_we_n = 1'b0;
      step(2);
      dl_active = 1'b0;
      step(2);
      hold_low = 1'b0;
      wait_log("ct_wait", 3, 100);
      check("ct_rdy_not_yet", 32'(cpu_rdy), 32'd0);
      check("ct_0_addr", 32'(log_q[0].addr), 32'h30);
      check("ct_1_addr", 32'(log_q[1].addr), 32'h31);
      check("ct_2_we",   32'(log_q[2].we), 32'd1);
      check("ct_2_addr", 32'(log_q[2].addr), 32'h40);
      check("ct_2_data", 32'(log_q[2].data), 32'h77);
      wait_rdy("ct_rdy", 40);
      check("ct_cnt", 32'(log_q.size()), 32'd3);
      cpu_cs_n = 1'b1; cpu_we_n = 1'b1;
      step(4);

      // Address change while cs_n stays low
      log_q.delete();
      busy_cycles = 5; rd_val = 8'h5C;
      cpu_addr = 23'h000010; cpu_cs_n = 1'b0; cpu_oe_n = 1'b0;
      wait_rdy("ac_rdy_10", 40);
      check("ac_dout_10", 32'(cpu_dout), 32'h5C);
      check("ac_addr_10", 32'(log_q[0].addr), 32'h10);
      rd_val = 8'h3D;
      cpu_addr = 23'h000011;
      step(2);
      check("ac_rdy_drop", 32'(cpu_rdy), 32'd0);
      wait_rdy("ac_rdy_11", 40);
      check("ac_cnt",     32'(log_q.size()), 32'd2);
      check("ac_op_11",   32'(log_q[1].we), 32'd0);
      check("ac_addr_11", 32'(log_q[1].addr), 32'h11);
      check("ac_dout_11", 32'(cpu_dout), 32'h3D);
      cpu_cs_n = 1'b1; cpu_oe_n = 1'b1;
      step(4);

      // Reset while waiting on a CPU read
      log_q.delete();
      busy_cycles = 8; rd_val = 8'hEE;
      cpu_addr = 23'h000055; cpu_din = 8'h66; cpu_cs_n = 1'b0; cpu_oe_n = 1'b0;
      wait_log("mr_issue", 1, 20);
      step(2);
      base = log_q.size();
      #2 reset_n = 1'b0;
      #1;
      check("mr_mem_addr", 32'(mem_addr), 32'd0);
      check("mr_mem_din",  32'(mem_din), 32'd0);
      check("mr_mem_rd",   32'(mem_rd), 32'd0);
      check("mr_mem_we",   32'(mem_we), 32'd0);
      check("mr_cpu_dout", 32'(cpu_dout), 32'd0);
      check("mr_cpu_rdy",  32'(cpu_rdy), 32'd0);
      cpu_cs_n = 1'b1; cpu_oe_n = 1'b1;
      step(2);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_sys);
         if (mem_we || mem_rd) seen = 1'b1;
      end
      check("mr_no_spurious", 32'(seen), 32'd0);
      check("mr_log_cnt",     32'(log_q.size()), 32'(base));
      check("mr_rdy_low",     32'(cpu_rdy), 32'd0);
      check("proto_bad_cmd",  32'(bad_cmd), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
